// File: rtl/tipi_nib_pkg.sv
// tipi_nib_pkg: shared target encodings, FSM states and byte geometry for the TIPI nibble receiver
package tipi_nib_pkg;
  localparam logic TGT_RD = 1'b0;
  localparam logic TGT_RC = 1'b1;
  localparam logic [1:0] NIBBLES_PER_BYTE = 2'd2;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;
  function automatic logic [1:0] tgt_sel(input logic tgt);
    return (tgt == TGT_RC) ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/tipi_sync_edge.sv
// tipi_sync_edge: multi-flop synchroniser with a registered single-cycle rising-edge pulse
module tipi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  // shift the async level in and flag the 0->1 transition one stage ahead of the chain end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      o_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      o_rise <= r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
    end
  end
endmodule

// File: rtl/tipi_nib_rx_ctrl.sv
// tipi_nib_rx_ctrl: turns Pi nibble/latch strobes into single-cycle shift-register select and latch pulses
module tipi_nib_rx_ctrl
  import tipi_nib_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pi_clk,
  input  logic       pi_le,
  input  logic [1:0] pi_rs,
  input  logic [3:0] pi_din,
  input  logic       err_clr,
  output logic [3:0] sr_din,
  output logic [1:0] sr_sel,
  output logic       sr_le,
  output logic       byte_done,
  output logic       err_short,
  output logic       err_over,
  output logic       err_rs
);
  logic                        w_clk_rise, w_le_rise;
  logic [SYNC_STAGES-1:0][1:0] r_rs_sync;
  logic [SYNC_STAGES-1:0][3:0] r_din_sync;
  state_e                      r_state;
  logic [1:0]                  r_cnt;
  logic                        r_tgt, r_pend_clk, r_pend_le;
  logic [1:0]                  w_rs, w_cnt_nib;
  logic [3:0]                  w_din;
  logic                        w_rs_ok, w_clk_ev, w_le_ev, w_do_clk, w_do_le;

  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_edge (
    .clk(clk), .rst(reset), .i_d(pi_clk), .o_rise(w_clk_rise)
  );
  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_le_edge (
    .clk(clk), .rst(reset), .i_d(pi_le), .o_rise(w_le_rise)
  );

  assign w_rs      = r_rs_sync[SYNC_STAGES-1];
  assign w_din     = r_din_sync[SYNC_STAGES-1];
  assign w_rs_ok   = ~w_rs[1];
  assign w_clk_ev  = w_clk_rise | r_pend_clk;
  assign w_le_ev   = w_le_rise | r_pend_le;
  assign w_do_clk  = (r_state == IDLE) & w_clk_ev;
  assign w_do_le   = w_le_ev & (((r_state == IDLE) & ~w_clk_ev) | (r_state == SHIFT));
  assign w_cnt_nib = (r_cnt == 2'd1 && w_rs[0] != r_tgt) ? 2'd1 :
                     (r_cnt == NIBBLES_PER_BYTE) ? r_cnt : r_cnt + 2'd1;

  // plain level synchronisers for the select and data buses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rs_sync  <= '0;
      r_din_sync <= '0;
    end else begin
      r_rs_sync  <= {r_rs_sync[SYNC_STAGES-2:0], pi_rs};
      r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], pi_din};
    end
  end

  // sequencer: nibbles win over latches in IDLE, a latch may follow a shift directly, the rest waits in pending flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_tgt      <= TGT_RD;
      r_pend_clk <= 1'b0;
      r_pend_le  <= 1'b0;
      sr_din     <= '0;
      sr_sel     <= '0;
      sr_le      <= 1'b0;
      byte_done  <= 1'b0;
      err_short  <= 1'b0;
      err_over   <= 1'b0;
      err_rs     <= 1'b0;
    end else begin
      r_state    <= IDLE;
      sr_sel     <= '0;
      sr_le      <= 1'b0;
      byte_done  <= 1'b0;
      r_pend_clk <= w_clk_ev & ~w_do_clk;
      r_pend_le  <= w_le_ev & ~w_do_le;
      if (err_clr) begin
        err_short <= 1'b0;
        err_over  <= 1'b0;
        err_rs    <= 1'b0;
      end
      if (w_do_clk) begin
        if (!w_rs_ok) begin
          err_rs <= 1'b1;
        end else begin
          r_state <= SHIFT;
          sr_din  <= w_din;
          sr_sel  <= tgt_sel(w_rs[0]);
          r_tgt   <= w_rs[0];
          r_cnt   <= w_cnt_nib;
          if (r_cnt == NIBBLES_PER_BYTE) err_over <= 1'b1;
        end
      end
      if (w_do_le) begin
        if (!w_rs_ok) begin
          err_rs <= 1'b1;
        end else if (r_cnt == NIBBLES_PER_BYTE && w_rs[0] == r_tgt) begin
          r_state   <= LATCH;
          sr_sel    <= tgt_sel(r_tgt);
          sr_le     <= 1'b1;
          byte_done <= 1'b1;
          r_cnt     <= '0;
        end else begin
          r_cnt <= '0;
          if (r_cnt != NIBBLES_PER_BYTE) err_short <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tipi_nib_rx_ctrl.sv
// tb_tipi_nib_rx_ctrl: scoreboard bench with a protocol-level model and an attached shift-register model
module tb_tipi_nib_rx_ctrl;
  logic clk = 0, reset = 1, pi_clk = 0, pi_le = 0, err_clr = 0;
  logic [1:0] pi_rs = 0;
  logic [3:0] pi_din = 0;
  logic [3:0] sr_din;
  logic [1:0] sr_sel;
  logic sr_le, byte_done, err_short, err_over, err_rs;

  tipi_nib_rx_ctrl dut (
    .clk(clk), .reset(reset), .pi_clk(pi_clk), .pi_le(pi_le), .pi_rs(pi_rs), .pi_din(pi_din),
    .err_clr(err_clr), .sr_din(sr_din), .sr_sel(sr_sel), .sr_le(sr_le), .byte_done(byte_done),
    .err_short(err_short), .err_over(err_over), .err_rs(err_rs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic       le;
    logic [3:0] din;
    logic [7:0] bval;
    bit         adj;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0, cyc = 0, last_cyc = -10;
  int m_cnt = 0;
  bit m_tgt = 0;
  logic [2:0] m_err = 0;
  logic [7:0] m_sreg [2];
  logic [7:0] t_sreg [2];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] sel_of(input bit t);
    return t ? 2'b10 : 2'b01;
  endfunction

  // model: a nibble with rs goes to register rs; two same-target nibbles make a byte
  task automatic model_nib(input logic [1:0] rs, input logic [3:0] d);
    exp_t e;
    if (rs > 1) begin
      m_err[0] = 1;
    end else begin
      e.sel = sel_of(rs[0]); e.le = 0; e.din = d; e.bval = 0; e.adj = 0;
      q.push_back(e);
      m_sreg[rs[0]] = {m_sreg[rs[0]][3:0], d};
      if (m_cnt == 2) m_err[1] = 1;
      else if (m_cnt == 1 && rs[0] != m_tgt) m_cnt = 1;
      else m_cnt = m_cnt + 1;
      m_tgt = rs[0];
    end
  endtask

  task automatic model_le(input logic [1:0] rs, input bit adj);
    exp_t e;
    if (rs > 1) begin
      m_err[0] = 1;
    end else if (m_cnt == 2 && rs[0] == m_tgt) begin
      e.sel = sel_of(m_tgt); e.le = 1; e.din = 0; e.bval = m_sreg[m_tgt]; e.adj = adj;
      q.push_back(e);
      m_cnt = 0;
    end else begin
      if (m_cnt < 2) m_err[2] = 1;
      m_cnt = 0;
    end
  endtask

  task automatic ev(input bit c, input bit l, input logic [1:0] rs, input logic [3:0] d, input bit lat);
    pi_rs = rs; pi_din = d;
    tick(4);
    pi_clk = c; pi_le = l;
    if (c) model_nib(rs, d);
    if (l) model_le(rs, c);
    if (lat) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("lat_early", 32'(sr_sel), 0);
      @(negedge clk);
      chk("lat_sel", 32'(sr_sel), 32'(sel_of(rs[0])));
      tick(1);
    end else tick(3);
    pi_clk = 0; pi_le = 0;
    tick(6);
    chk("errs", 32'({err_short, err_over, err_rs}), 32'(m_err));
  endtask

  task automatic clr();
    err_clr = 1; tick(1); err_clr = 0; m_err = 0; tick(1);
    chk("err_clr", 32'({err_short, err_over, err_rs}), 0);
  endtask

  // monitor: every output pulse must match the next expected event, in order
  always @(negedge clk) begin
    exp_t e;
    bit t;
    if (!reset && (sr_sel != 0 || sr_le || byte_done)) begin
      if (q.size() == 0) begin
        chk("unexpected", 32'({sr_sel, sr_le, byte_done}), 0);
      end else begin
        e = q.pop_front();
        t = sr_sel[1];
        chk("sel", 32'(sr_sel), 32'(e.sel));
        chk("le_bd", 32'({sr_le, byte_done}), 32'({e.le, e.le}));
        if (e.adj) chk("adjacent", 32'(cyc), 32'(last_cyc + 1));
        if (e.le) chk("byte", 32'(t_sreg[t]), 32'(e.bval));
        else begin
          chk("din", 32'(sr_din), 32'(e.din));
          t_sreg[t] = {t_sreg[t][3:0], sr_din};
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin
    logic [1:0] rs;
    int k;
    m_sreg[0] = 0; m_sreg[1] = 0; t_sreg[0] = 0; t_sreg[1] = 0;
    tick(3);
    chk("rst_out", 32'({sr_din, sr_sel, sr_le, byte_done, err_short, err_over, err_rs}), 0);
    reset = 0;
    tick(2);
    ev(1, 0, 2'd0, 4'hA, 1); ev(1, 0, 2'd0, 4'h5, 0); ev(0, 1, 2'd0, 4'h0, 0);
    ev(1, 0, 2'd1, 4'h3, 0); ev(0, 1, 2'd1, 4'h0, 0);
    chk("short_flag", 32'(err_short), 1);
    clr();
    ev(1, 0, 2'd1, 4'hC, 0); ev(1, 0, 2'd1, 4'h3, 0); ev(0, 1, 2'd1, 4'h0, 0);
    ev(1, 0, 2'd0, 4'h1, 0); ev(1, 0, 2'd0, 4'h2, 0); ev(1, 0, 2'd0, 4'h3, 0); ev(0, 1, 2'd0, 4'h0, 0);
    chk("over_flag", 32'(err_over), 1);
    clr();
    ev(1, 0, 2'd0, 4'h7, 0); ev(1, 1, 2'd0, 4'h9, 0);
    ev(1, 0, 2'd2, 4'hF, 0);
    chk("rs_flag", 32'(err_rs), 1);
    clr();
    ev(1, 0, 2'd0, 4'h4, 0);
    #2 reset = 1;
    #1 chk("rst_mid", 32'({sr_din, sr_sel, sr_le, byte_done, err_short, err_over, err_rs}), 0);
    m_cnt = 0; m_err = 0;
    tick(3);
    reset = 0;
    tick(3);
    ev(1, 0, 2'd0, 4'h6, 0); ev(1, 0, 2'd0, 4'hE, 0); ev(0, 1, 2'd0, 4'h0, 0);
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      rs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : {1'b0, 1'($urandom_range(0, 1))};
      if (k <= 8 && m_cnt >= (k == 8 ? 1 : 2) && !rs[1]) rs = {1'b0, m_tgt};
      if (k < 5) ev(1, 0, rs, 4'($urandom), 0);
      else if (k < 8) ev(0, 1, rs, 4'($urandom), 0);
      else if (k == 8) ev(1, 1, rs, 4'($urandom), 0);
      else clr();
    end
    for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
    chk("drain", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tipi_nib_rx_ctrl.md
# tipi_nib_rx_ctrl

Sequencer that turns the Raspberry Pi's asynchronous nibble-strobe protocol into the single-cycle select and latch-enable pulses that drive the TIPI nibble-in/byte-out shift registers. It synchronises the Pi strobes into the CPLD clock domain and counts nibbles per byte. It steers each nibble to one of two target registers, data (RD) or control (RC), and flags protocol errors. It sits between the Pi GPIO pins and the shift-register instances in the TIPI PEB top level.

## Interface
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser; minimum 2.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- pi_clk  in  1  async nibble strobe; each rising edge delivers one nibble.
- pi_le  in  1  async latch request; each rising edge commits the assembled byte.
- pi_rs  in  2  async target select: 0 = RD, 1 = RC, 2/3 reserved.
- pi_din  in  4  async nibble data, MSB first ([0:3]).
- sr_din  out  4  registered nibble presented to the shift registers.
- sr_sel  out  2  one-hot select pulse; bit 0 = RD, bit 1 = RC.
- sr_le  out  1  latch-enable, valid only while an sr_sel bit is high.
- byte_done  out  1  one-cycle pulse when a complete byte is latched.
- err_short  out  1  sticky: latch requested with fewer than 2 nibbles.
- err_over  out  1  sticky: third nibble arrived before a latch.
- err_rs  out  1  sticky: nibble or latch with a reserved pi_rs.
- err_clr  in  1  synchronous; clears all three sticky error flags.

## Operation
- pi_clk, pi_le, pi_rs and pi_din each pass through SYNC_STAGES flops.
- Rising edges are detected on the synchronised pi_clk and pi_le.
- Pi protocol requirements:
  - pi_din and pi_rs are stable from at least SYNC_STAGES+1 clk cycles before a pi_clk or pi_le edge until after that edge.
  - Events are spaced at least 2 clk cycles apart.
- State machine states: IDLE, SHIFT, LATCH.
  - IDLE to SHIFT on a pi_clk edge with a valid rs. The synchronised nibble is captured into sr_din, the target is captured, and the nibble count increments, saturating at 2.
  - SHIFT: sr_sel[target] = 1 and sr_le = 0 for exactly one cycle, then back to IDLE, or to LATCH if a latch is pending.
  - IDLE to LATCH on a pi_le edge when count = 2 and the rs matches the captured target.
  - LATCH: sr_sel[target] = 1, sr_le = 1, and byte_done = 1 for one cycle. Count clears and the state returns to IDLE.
- Latch with count < 2: no select or latch is issued, err_short sets, and count clears.
- Nibble arriving at count = 2: the shift is still issued (the register keeps the last two nibbles), err_over sets, and count stays at 2.
- Nibble whose rs differs from the captured target while count = 1: the target switches and count becomes 1. No error is raised.
- Reserved rs on a nibble or latch: the event is dropped, err_rs sets, and count is unchanged.
- Simultaneous pi_clk and pi_le edges in the same cycle: the shift runs first and the latch is held pending, then issued the next cycle after the count update.
- An event arriving while in SHIFT or LATCH is held in a one-deep pending flag per event type.
- If an err flag sets and err_clr is asserted in the same cycle, the flag ends up set.

## Timing
- Reset values: sr_din = 0, sr_sel = 0, sr_le = 0, byte_done = 0, all err_* = 0. State is IDLE, count = 0, pending flags = 0, synchronisers = 0.
- Latency: a pi_clk rising edge sampled at clk edge N produces sr_sel high during the cycle after edge N+SYNC_STAGES, i.e. 3 edges with the default.
- A pi_le edge under the same conditions produces sr_le at the same latency.
- sr_din changes only on entry to SHIFT and is held stable during the select cycle.
- sr_sel is never wider than one cycle per event.
- At most one sr_sel bit is high in any cycle.
- Reset asserted mid-operation immediately zeroes all outputs. A partially assembled byte is discarded, and no latch occurs after reset releases.

## Structure
- Package tipi_nib_pkg holds:
  - the target encoding constants (TGT_RD = 0, TGT_RC = 1);
  - the state enum (IDLE, SHIFT, LATCH);
  - the NIBBLES_PER_BYTE = 2 constant.
- Sub-module tipi_sync_edge: a SYNC_STAGES-deep synchroniser with a registered rising-edge pulse output.
  - Instantiated once each for pi_clk and pi_le.
  - pi_rs and pi_din use plain synchroniser chains.

## Test plan
- Nibble-then-latch: rs = 0, nibbles 0xA then 0x5, then pi_le -> two single-cycle sr_sel = 01 pulses with sr_din = A then 5, then sr_sel = 01 with sr_le = 1 and byte_done = 1. The attached shift register outputs 0xA5.
- Short latch: rs = 1, one nibble 0x3, then pi_le -> one shift pulse, no sr_le, err_short = 1. A following full byte 0xC3 on rs = 1 latches correctly.
- Overrun: rs = 0, nibbles 1, 2, 3, then latch -> three shift pulses, err_over = 1, latched byte 0x23.
- Simultaneous edges: pi_clk and pi_le rise together at count = 1 -> shift cycle followed immediately by latch cycle, byte_done = 1, no error.
- Reserved rs and reset: rs = 2 with a nibble -> no sr_sel and err_rs = 1; err_clr clears the flag. Asserting reset between the nibbles of a byte leaves all outputs 0, and a fresh 2-nibble byte then latches normally.
